// File: rtl/lb_arbiter_if.sv
// Bus bundle for lb_arbiter.
// Groups three sets of signals: master A (fixed-timing strobes), master B (req/gnt handshake),
// and the local-bus slave side. It also carries the B-wait statistics.
// The 'slave' modport is the arbiter's view. The 'master' modport is the environment's view:
// both masters plus the local-bus slaves.
interface lb_arbiter_if #(
    parameter int unsigned CW = 16
) ();
    // Master A
    logic          a_strobe;
    logic          a_rd;
    logic [23:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [31:0]   a_rdata;
    logic          a_rvalid;
    // Master B
    logic          b_req;
    logic          b_rd;
    logic [23:0]   b_addr;
    logic [31:0]   b_wdata;
    logic          b_gnt;
    logic [31:0]   b_rdata;
    logic          b_rvalid;
    // Local bus
    logic [23:0]   lb_addr;
    logic          lb_strobe;
    logic          lb_rd;
    logic          lb_write;
    logic [31:0]   lb_wdata;
    logic [31:0]   lb_rdata;
    // Statistics
    logic [CW-1:0] b_wait_max;
    logic          clr_stats;

    modport slave (
        input  a_strobe, a_rd, a_addr, a_wdata,
        output a_rdata, a_rvalid,
        input  b_req, b_rd, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid,
        output lb_addr, lb_strobe, lb_rd, lb_write, lb_wdata,
        input  lb_rdata,
        output b_wait_max,
        input  clr_stats
    );

    modport master (
        output a_strobe, a_rd, a_addr, a_wdata,
        input  a_rdata, a_rvalid,
        output b_req, b_rd, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid,
        input  lb_addr, lb_strobe, lb_rd, lb_write, lb_wdata,
        output lb_rdata,
        input  b_wait_max,
        output clr_stats
    );
endinterface

// File: rtl/lb_arbiter.sv
// Two-master local-bus arbiter.
// Master A always wins. Master B is granted when A is idle, but never in two consecutive cycles.
// The winning transaction is registered onto the local bus.
// A tag pipeline of RD_LAT entries routes read data back to the issuing master.
// The longest B request-to-grant wait is tracked in a saturating counter.
// Ports:
//   clk     - single clock
//   reset_n - asynchronous active-low reset
//   bus     - lb_arbiter_if.slave: master A, master B, local bus, statistics
module lb_arbiter #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned CW     = 16
) (
    input logic         clk,
    input logic         reset_n,
    lb_arbiter_if.slave bus
);
    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    logic              a_win, b_win, gnt_q;
    logic              lb_strobe_q, lb_strobe_d, lb_rd_q, lb_rd_d, lb_own_q, lb_own_d;
    logic [23:0]       lb_addr_q, lb_addr_d;
    logic [31:0]       lb_wdata_q, lb_wdata_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d, tag_own_q, tag_own_d;
    logic              tail_vld, tail_own;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [31:0]       a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [CW-1:0]     cnt_q, cnt_d, wait_max_q, wait_max_d;

    // Arbitration; gnt_q blocks a second grant on a request that is still held after its grant.
    always_comb begin
        a_win = bus.a_strobe;
        b_win = ~bus.a_strobe & bus.b_req & ~gnt_q;
    end

    // Local-bus register: address/rd/wdata hold when idle; owner 1 means master B.
    always_comb begin
        lb_strobe_d = a_win | b_win;
        lb_rd_d     = lb_rd_q;
        lb_addr_d   = lb_addr_q;
        lb_wdata_d  = lb_wdata_q;
        lb_own_d    = lb_own_q;
        if (a_win) begin
            lb_rd_d    = bus.a_rd;
            lb_addr_d  = bus.a_addr;
            lb_wdata_d = bus.a_wdata;
            lb_own_d   = 1'b0;
        end else if (b_win) begin
            lb_rd_d    = bus.b_rd;
            lb_addr_d  = bus.b_addr;
            lb_wdata_d = bus.b_wdata;
            lb_own_d   = 1'b1;
        end
    end

    // Tag pipeline: the tail lines up with lb_rdata being valid for that read.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_own_d    = tag_own_q;
        tag_vld_d[0] = lb_strobe_q & lb_rd_q;
        tag_own_d[0] = lb_own_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
        tail_vld = tag_vld_q[RD_LAT-1];
        tail_own = tag_own_q[RD_LAT-1];
    end

    always_comb begin
        a_rvalid_d = tail_vld & ~tail_own;
        b_rvalid_d = tail_vld & tail_own;
        a_rdata_d  = a_rvalid_d ? bus.lb_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? bus.lb_rdata : b_rdata_q;
    end

    // Wait statistics: cnt_q is the number of cycles B has waited before the current cycle.
    always_comb begin
        cnt_d      = cnt_q;
        wait_max_d = wait_max_q;
        if (b_win) begin
            cnt_d = '0;
            if (cnt_q > wait_max_q) begin
                wait_max_d = cnt_q;
            end
        end else if (bus.b_req) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
        if (bus.clr_stats) begin
            wait_max_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q       <= 1'b0;
            lb_strobe_q <= 1'b0;
            lb_rd_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_wdata_q  <= '0;
            lb_own_q    <= 1'b0;
            tag_vld_q   <= '0;
            tag_own_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            cnt_q       <= '0;
            wait_max_q  <= '0;
        end else begin
            gnt_q       <= b_win;
            lb_strobe_q <= lb_strobe_d;
            lb_rd_q     <= lb_rd_d;
            lb_addr_q   <= lb_addr_d;
            lb_wdata_q  <= lb_wdata_d;
            lb_own_q    <= lb_own_d;
            tag_vld_q   <= tag_vld_d;
            tag_own_q   <= tag_own_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            cnt_q       <= cnt_d;
            wait_max_q  <= wait_max_d;
        end
    end

    assign bus.b_gnt      = b_win;
    assign bus.lb_strobe  = lb_strobe_q;
    assign bus.lb_rd      = lb_rd_q;
    assign bus.lb_write   = lb_strobe_q & ~lb_rd_q;
    assign bus.lb_addr    = lb_addr_q;
    assign bus.lb_wdata   = lb_wdata_q;
    assign bus.a_rdata    = a_rdata_q;
    assign bus.a_rvalid   = a_rvalid_q;
    assign bus.b_rdata    = b_rdata_q;
    assign bus.b_rvalid   = b_rvalid_q;
    assign bus.b_wait_max = wait_max_q;
endmodule

// File: tb/tb_lb_arbiter.sv
// Self-checking bench for lb_arbiter.
// Directed scenarios run first, then a random traffic phase.
// Every cycle is compared against a transaction-level reference model.
module tb_lb_arbiter;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned CW     = 16;
    localparam int          RING   = 64;
    localparam int          MAXC   = (1 << CW) - 1;

    typedef struct {
        logic        rd;
        logic [23:0] addr;
        logic [31:0] wdata;
    } breq_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    lb_arbiter_if #(.CW(CW)) bus ();

    lb_arbiter #(.RD_LAT(RD_LAT), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_gnt    = 0;

    // Reference model state
    breq_t       bq[$];
    bit          m_prev_gnt;
    bit          m_stb, m_rd;
    logic [23:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_a_rdata, m_b_rdata;
    int          m_cnt, m_max;
    bit          ev_v[RING];
    bit          ev_own[RING];
    logic [31:0] ev_d[RING];
    // Local-bus slave model
    bit          sl_v[RING];
    logic [31:0] sl_d[RING];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [23:0] a);
        if (a == 24'h000010) return 32'h1234_5678;
        return {a[7:0], a} ^ 32'h5A5A_0000;
    endfunction

    task automatic model_clear();
        bq.delete();
        m_prev_gnt = 1'b0;
        m_stb = 1'b0; m_rd = 1'b0; m_addr = '0; m_wd = '0;
        m_a_rdata = '0; m_b_rdata = '0;
        m_cnt = 0; m_max = 0;
        for (int i = 0; i < RING; i++) begin
            ev_v[i] = 1'b0;
            sl_v[i] = 1'b0;
        end
    endtask

    task automatic drive_idle();
        bus.a_strobe = 1'b0; bus.a_rd = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_rd = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.clr_stats = 1'b0; bus.lb_rdata = '0;
    endtask

    // Called just after a rising edge; asserts reset and checks outputs clear immediately.
    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        #1;
        check_eq("rst_lb_strobe", bus.lb_strobe, 0);
        check_eq("rst_lb_rd", bus.lb_rd, 0);
        check_eq("rst_lb_write", bus.lb_write, 0);
        check_eq("rst_lb_addr", bus.lb_addr, 0);
        check_eq("rst_lb_wdata", bus.lb_wdata, 0);
        check_eq("rst_a_rdata", bus.a_rdata, 0);
        check_eq("rst_a_rvalid", bus.a_rvalid, 0);
        check_eq("rst_b_rdata", bus.b_rdata, 0);
        check_eq("rst_b_rvalid", bus.b_rvalid, 0);
        check_eq("rst_b_gnt", bus.b_gnt, 0);
        check_eq("rst_b_wait_max", bus.b_wait_max, 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc += 3;
    endtask

    // One bus cycle: apply inputs, compare outputs at the falling edge, advance the model.
    task automatic tick(input bit a_stb, input bit a_rd, input logic [23:0] a_addr,
                        input logic [31:0] a_wd, input bit clr);
        bit    b_req_now, b_win, a_v, b_v;
        int    slot, rslot;
        breq_t hd;
        bus.a_strobe = a_stb; bus.a_rd = a_rd; bus.a_addr = a_addr; bus.a_wdata = a_wd;
        b_req_now = (bq.size() > 0);
        if (b_req_now) begin
            hd = bq[0];
        end else begin
            hd.rd = 1'($urandom); hd.addr = 24'($urandom); hd.wdata = $urandom;
        end
        bus.b_req = b_req_now; bus.b_rd = hd.rd; bus.b_addr = hd.addr; bus.b_wdata = hd.wdata;
        bus.clr_stats = clr;
        @(negedge clk);
        check_eq("lb_strobe", bus.lb_strobe, m_stb);
        check_eq("lb_write", bus.lb_write, m_stb & ~m_rd);
        check_eq("lb_rd", bus.lb_rd, m_rd);
        check_eq("lb_addr", bus.lb_addr, m_addr);
        check_eq("lb_wdata", bus.lb_wdata, m_wd);
        slot = cyc % RING;
        a_v = ev_v[slot] && !ev_own[slot];
        b_v = ev_v[slot] && ev_own[slot];
        if (a_v) m_a_rdata = ev_d[slot];
        if (b_v) m_b_rdata = ev_d[slot];
        ev_v[slot] = 1'b0;
        check_eq("a_rvalid", bus.a_rvalid, a_v);
        check_eq("a_rdata", bus.a_rdata, m_a_rdata);
        check_eq("b_rvalid", bus.b_rvalid, b_v);
        check_eq("b_rdata", bus.b_rdata, m_b_rdata);
        check_eq("b_wait_max", bus.b_wait_max, m_max);
        b_win = !a_stb && b_req_now && !m_prev_gnt;
        check_eq("b_gnt", bus.b_gnt, b_win);
        if (bus.b_gnt) n_gnt++;
        // Slave answers a read RD_LAT cycles after its strobe; garbage otherwise.
        if (bus.lb_strobe && bus.lb_rd) begin
            sl_v[(cyc + RD_LAT) % RING] = 1'b1;
            sl_d[(cyc + RD_LAT) % RING] = slave_data(bus.lb_addr);
        end
        bus.lb_rdata = sl_v[slot] ? sl_d[slot] : $urandom;
        sl_v[slot] = 1'b0;
        // Model update
        if (b_win) begin
            if (m_cnt > m_max) m_max = m_cnt;
            m_cnt = 0;
        end else if (b_req_now) begin
            m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
        end else begin
            m_cnt = 0;
        end
        if (clr) m_max = 0;
        if (a_stb || b_win) begin
            m_stb  = 1'b1;
            m_rd   = a_stb ? a_rd : hd.rd;
            m_addr = a_stb ? a_addr : hd.addr;
            m_wd   = a_stb ? a_wd : hd.wdata;
            if (m_rd) begin
                rslot = (cyc + RD_LAT + 2) % RING;
                ev_v[rslot]   = 1'b1;
                ev_own[rslot] = b_win;
                ev_d[rslot]   = slave_data(m_addr);
            end
        end else begin
            m_stb = 1'b0;
        end
        m_prev_gnt = b_win;
        if (b_win) void'(bq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom), 24'($urandom), $urandom, 1'b0);
    endtask

    initial begin
        breq_t r;
        drive_idle();
        #2;
        do_reset();

        // A-only traffic
        tick(1'b1, 1'b0, 24'h000010, 32'hDEAD_BEEF, 1'b0);
        idle(7);
        tick(1'b1, 1'b1, 24'h000010, 32'h0, 1'b0);
        idle(6);
        check_eq("aonly_a_rdata", bus.a_rdata, 32'h1234_5678);

        // Collision: B request rises with an A read
        r.rd = 1'b1; r.addr = 24'h000020; r.wdata = 32'h0;
        bq.push_back(r);
        tick(1'b1, 1'b1, 24'h000030, 32'h0, 1'b0);
        idle(8);
        check_eq("coll_wait_max", bus.b_wait_max, 1);
        check_eq("coll_b_rdata", bus.b_rdata, slave_data(24'h000020));

        // B stream of 10 reads
        n_gnt = 0;
        for (int i = 0; i < 10; i++) begin
            r.rd = 1'b1; r.addr = 24'h000100 + 24'(i); r.wdata = $urandom;
            bq.push_back(r);
        end
        for (int i = 0; i < 60 && bq.size() > 0; i++) idle(1);
        check_eq("bstream_drained", bq.size(), 0);
        idle(6);
        check_eq("bstream_grants", n_gnt, 10);
        check_eq("bstream_last_data", bus.b_rdata, slave_data(24'h000109));

        // Spacing violation: A strobes six cycles in a row while B waits
        r.rd = 1'b0; r.addr = 24'h000200; r.wdata = 32'hCAFE_0001;
        bq.push_back(r);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 24'h000300 + 24'(i), $urandom, 1'b0);
        idle(3);
        check_eq("viol_wait_max", bus.b_wait_max, 6);
        tick(1'b0, 1'b0, 24'h0, 32'h0, 1'b1);
        check_eq("viol_clr", bus.b_wait_max, 0);
        idle(2);

        // Reset while an A read is in flight
        tick(1'b1, 1'b1, 24'h000040, 32'h0, 1'b0);
        idle(1);
        do_reset();
        idle(8);
        tick(1'b1, 1'b1, 24'h000050, 32'h0, 1'b0);
        idle(6);
        check_eq("post_rst_a_rdata", bus.a_rdata, slave_data(24'h000050));

        // Random traffic, including occasional A-spacing violations and stats clears
        for (int i = 0; i < 2000; i++) begin
            if (bq.size() == 0 && ($urandom % 3) == 0) begin
                r.rd = 1'($urandom); r.addr = 24'($urandom); r.wdata = $urandom;
                bq.push_back(r);
            end
            tick(($urandom % 4) == 0, 1'($urandom), 24'($urandom), $urandom,
                 ($urandom % 100) == 0);
        end
        bq.delete();
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lb_arbiter.md
# lb_arbiter

Two-master arbiter for the 24-bit local bus. It sits between the UDP memory gateway (master A, which issues fixed-timing strobes and cannot stall) and an on-chip sequencer (master B, which uses a req/gnt handshake). The local-bus slaves see a single registered master. A tag pipeline returns read data to whichever master issued the read, after the fixed bus read latency.

## Interface
Parameters:
- `RD_LAT`, default 2: cycles from `lb_strobe` to valid `lb_rdata`. Minimum 1.
- `CW`, default 16: width of the saturating B-wait statistics counter.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `a_strobe` in 1: master A transaction strobe, one cycle.
- `a_rd` in 1: master A read (1) or write (0); qualified by `a_strobe`.
- `a_addr` in 24: master A address.
- `a_wdata` in 32: master A write data.
- `a_rdata` out 32: read data returned to A.
- `a_rvalid` out 1: one-cycle pulse; `a_rdata` is valid.
- `b_req` in 1: master B request; held until granted.
- `b_rd` in 1: master B read (1) or write (0).
- `b_addr` in 24: master B address.
- `b_wdata` in 32: master B write data.
- `b_gnt` out 1: one-cycle accept pulse.
- `b_rdata` out 32: read data returned to B.
- `b_rvalid` out 1: one-cycle pulse; `b_rdata` is valid.
- `lb_addr` out 24: local-bus address.
- `lb_strobe` out 1: local-bus transaction strobe.
- `lb_rd` out 1: local-bus read level.
- `lb_write` out 1: equals `lb_strobe & ~lb_rd`.
- `lb_wdata` out 32: local-bus write data.
- `lb_rdata` in 32: local-bus read data from the slaves.
- `b_wait_max` out CW: longest observed `b_req`-to-`b_gnt` wait, in cycles. Saturating.
- `clr_stats` in 1: synchronous clear of `b_wait_max`.

## Operation
- **Arbitration** is evaluated every cycle.
  - If `a_strobe` is high, A wins unconditionally.
  - Otherwise, if `b_req` is high and `b_gnt` was not asserted in the previous cycle, B wins.
  - Otherwise the bus is idle.
- **B grant.** `b_gnt` is combinational in the cycle B wins. B must drop `b_req`, or present its next request, on the following cycle. The previous-cycle `b_gnt` block prevents a double grant on one held request.
- **Bus outputs.** The winner's `addr`/`rd`/`wdata` are registered into `lb_*`, and `lb_strobe` is registered high.
- **Idle bus.** `lb_addr`, `lb_rd` and `lb_wdata` hold their last values; `lb_strobe` is 0.
- **Tag pipeline.** A shift register of `RD_LAT` entries, each holding {valid, owner}.
  - An entry is inserted when `lb_strobe & lb_rd` is high.
  - At the tail, `lb_rdata` is registered into `a_rdata` or `b_rdata` (chosen by owner), with a matching `*_rvalid` pulse.
  - Writes insert no tag.
  - Owner data registers hold their value between pulses.
- **Pipelined reads.** Back-to-back reads are legal: up to `RD_LAT` reads can be in flight. Tags from different owners are never reordered.
- **Wait counter.**
  - Counts cycles while `b_req & ~b_gnt`.
  - On `b_gnt`, `b_wait_max` takes max(`b_wait_max`, count); the count then resets.
  - Saturates at 2^CW−1.
- **Simultaneous `clr_stats` and grant.** `clr_stats` wins: `b_wait_max` becomes 0.
- **Reset** clears everything:
  - `lb_*`, `a_*` and `b_*` outputs, all tags, the wait count and `b_wait_max` go to 0.
  - Reads in flight when reset asserts produce no `rvalid` after release.

## Timing
- **Strobe latency.** A or B strobe to `lb_strobe`: 1 cycle.
- **A read latency.** `a_strobe` (read) to `a_rvalid`: RD_LAT+2 cycles. The gateway's `read_pipe_len` is set to RD_LAT+2.
- **B read latency.** `b_gnt` to `b_rvalid`: RD_LAT+2 cycles.
- **A spacing contract.** Master A strobes are at least 4 cycles apart.
  - B is therefore granted within 4 cycles of `b_req`, and `b_wait_max` ≤ 3 in normal use.
  - A value above 3 flags an A-spacing violation.
- **B throughput.** B alone gets at most one grant every 2 cycles, because of the previous-cycle block.

## Test plan
- **A-only traffic.**
  - Stimulus: A write to 0x000010 with 0xDEADBEEF, then an A read 8 cycles later. `lb_rdata` model returns 0x12345678.
  - Required: `lb_write` pulses 1 cycle after `a_strobe`, carrying the correct address and data. `a_rvalid` pulses RD_LAT+2 cycles after the read strobe with `a_rdata`=0x12345678. `b_rvalid` stays 0.
- **Collision.**
  - Stimulus: `b_req` (read 0x000020) rises in the same cycle as an A read of 0x000030.
  - Required: A is issued first; `b_gnt` comes the next cycle. `a_rdata` and `b_rdata` carry their own slaves' data, in order, 1 cycle apart. `b_wait_max`=1.
- **B stream.**
  - Stimulus: `b_req` held for 10 reads; address increments on each `b_gnt`.
  - Required: grants every 2 cycles, 10 `b_rvalid` pulses, data in order, no duplicate grants.
- **Spacing violation.**
  - Stimulus: A strobes every cycle for 6 cycles while `b_req` is high.
  - Required: `b_gnt` only after A stops. `b_wait_max`=6. Then assert `clr_stats` → 0.
- **Reset mid-read.**
  - Stimulus: assert `reset_n`=0 one cycle after an A read reaches `lb_strobe`.
  - Required: all outputs are 0 immediately, with no `a_rvalid` after release. A new read completes with normal latency.
